if_fetch_queue: RTL
===================

// Module: if_fetch_queue
// PURPOSE
//  Parametrised instruction-fetch stage: PC register, synchronous imem request, DEPTH-entry fetch buffer, valid/ready to decode.
//  Supports stalls via backpressure and redirects (PC-relative or absolute) with flush of buffered/in-flight fetches.
//  Sits between imem (1-cycle synchronous read) and the decode stage; replaces the unbuffered PC/select fetch path.
// PARAMETERS
//  XLEN      16      PC / address width (word-addressed, +1 per instruction)
//  ILEN      16      instruction width
//  DEPTH     4       fetch-buffer entries (power of 2, >=2)
//  RESET_PC  'h0     PC loaded at reset
// PORTS
//  clk          in   1     clock, all state on rising edge
//  rst          in   1     synchronous, active-high reset
//  redir_valid  in   1     redirect request (branch/jump resolved downstream)
//  redir_abs    in   1     1: target = redir_base; 0: target = redir_base + redir_off
//  redir_base   in   XLEN  absolute target, or PC of redirecting instruction
//  redir_off    in   XLEN  signed offset (already sign-extended by caller)
//  imem_en      out  1     fetch request this cycle
//  imem_addr    out  XLEN  fetch address (= current PC)
//  imem_rdata   in   ILEN  read data, valid exactly 1 cycle after imem_en
//  dec_valid    out  1     buffer head valid
//  dec_ready    in   1     decode accepts head
//  dec_instr    out  ILEN  head instruction
//  dec_pc       out  XLEN  head instruction PC
//  dec_pc_next  out  XLEN  dec_pc + 1 (link value)
// BEHAVIOUR
//  Reset: pc=RESET_PC, buffer empty, inflight=0; imem_en=0, dec_valid=0 during rst cycle; outputs X-free.
//  Fetch issue: imem_en = !rst & !redir_valid & (count + inflight < DEPTH); imem_addr = pc.
//   On issue pc <= pc+1 (mod 2^XLEN, wraps 'hFFFF->0 at XLEN=16); inflight <= 1, req PC captured.
//  Response: cycle after issue, {imem_rdata, req_pc} pushed to buffer unless killed. Space is reserved at issue, so push never overflows.
//  Dequeue: handshake when dec_valid & dec_ready; head popped same edge. Push and pop in same cycle allowed at any count.
//  Latency: redirect/reset -> first dec_valid = 2 cycles (issue, then push). Steady-state throughput 1 instr/cycle with dec_ready=1.
//  Backpressure: dec_ready=0 -> buffer fills to DEPTH, imem_en drops; head data/pc held stable while dec_valid & !dec_ready.
//  Redirect (highest priority after rst):
//   - target computed mod 2^XLEN; pc <= target.
//   - buffer flushed (count=0), in-flight response killed (not pushed), no imem_en that cycle.
//   - a pop in the same cycle is still reported as handshake to decode but data is discarded by the flush; decode owns squash.
//   - next cycle issues fetch at target.
//  Back-to-back redirects: last one wins; each kills prior in-flight.
//  Reset mid-operation: overrides redirect and fetch; in-flight response dropped.
//  State (no FSM enum needed): pc, inflight, req_pc, buffer rd/wr ptrs + count (log2(DEPTH)+1 bits).
// STRUCTURE
//  Package if_pkg: XLEN/ILEN defaults, RESET_PC, fetch_entry_t {instr, pc}.
//  Sub-module fetch_fifo (DEPTH, entry width = ILEN+XLEN): sync push/pop/flush, count, full/empty; flush dominates push.
//  Top: PC register, redirect target adder, issue logic, kill bit, dec_pc_next incrementer.
// TESTING
//  1 Reset, dec_ready=1, imem returns addr as data -> imem_addr 0,1,2..; dec_pc 0,1,2.. from cycle 2, dec_pc_next=dec_pc+1.
//  2 dec_ready=0 for 10 cycles -> exactly DEPTH=4 entries buffered, imem_en low afterwards; release -> pc 0..3 then 4.. in order, no gap >1 cycle.
//  3 redir_valid, abs=0, base=8, off=-3 ('hFFFD) -> next imem_addr=5; no instr from before redirect reaches decode; dec_pc=5 two cycles later.
//  4 redir abs=1 base='h0100 same cycle as response arrival and dec pop -> response dropped, buffer empty, next fetch 'h0100.
//  5 RESET_PC='hFFFE -> fetches 'hFFFE,'hFFFF,'h0000 (wrap), dec_pc_next of 'hFFFF is 'h0000.
//  6 rst asserted with full buffer and in-flight fetch -> next cycle dec_valid=0, imem_addr=RESET_PC, no stale push.

Source files
------------

// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Package : if_pkg
// Shared defaults and the fetch-buffer entry layout for the fetch stage.
// Rev     : 1.0
// ============================================================================
package if_pkg;

    localparam int              c_XLEN     = 16;
    localparam int              c_ILEN     = 16;
    localparam logic [c_XLEN-1:0] c_RESET_PC = '0;

    typedef struct packed {
        logic [c_ILEN-1:0] instr;
        logic [c_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module : fetch_fifo
// Synchronous FIFO with push/pop/flush and occupancy count; flush dominates.
// Rev    : 1.0
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [AW:0]      o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // Guard against misuse: never pop empty, never push full without a pop.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module : if_fetch_queue
// Instruction fetch: PC register, 1-cycle imem request, buffered valid/ready
// hand-off to decode, with redirect flush of buffered and in-flight fetches.
// Rev    : 1.0
// ============================================================================
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int              XLEN     = c_XLEN,
    parameter int              ILEN     = c_ILEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(c_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redir_valid,
    input  logic            redir_abs,
    input  logic [XLEN-1:0] redir_base,
    input  logic [XLEN-1:0] redir_off,
    output logic            imem_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [ILEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_pc_next
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]      r_pc;
    logic [XLEN-1:0]      r_req_pc;
    logic                 r_inflight;

    logic [XLEN-1:0]      w_target;
    logic [CW-1:0]        w_count;
    logic [CW-1:0]        w_occupancy;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_issue;
    logic                 w_push;
    logic                 w_pop;
    logic [ILEN+XLEN-1:0] w_head;

    assign w_target = redir_abs ? redir_base : (redir_base + redir_off);

    // Space is reserved at issue time, so the in-flight slot counts as used.
    assign w_occupancy = w_count + {{(CW-1){1'b0}}, r_inflight};
    assign w_issue     = ~rst & ~redir_valid & ~w_full & (w_occupancy < CW'(DEPTH));

    // A response landing in a redirect cycle is killed rather than buffered.
    assign w_push = r_inflight & ~redir_valid & ~rst;
    assign w_pop  = dec_valid & dec_ready;

    assign imem_en     = w_issue;
    assign imem_addr   = r_pc;
    assign dec_valid   = ~w_empty & ~rst;
    assign dec_instr   = w_head[ILEN+XLEN-1:XLEN];
    assign dec_pc      = w_head[XLEN-1:0];
    assign dec_pc_next = dec_pc + XLEN'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
        end else if (redir_valid) begin
            r_pc       <= w_target;
            r_inflight <= 1'b0;
        end else if (w_issue) begin
            r_pc       <= r_pc + XLEN'(1);
            r_req_pc   <= r_pc;
            r_inflight <= 1'b1;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ILEN + XLEN)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redir_valid),
        .i_wdata ({imem_rdata, r_req_pc}),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule
`default_nettype wire
